// File: rtl/rs_pkg.sv
// Shared types for the multi-issue reservation station.
// Optional RS_STATS_EN build adds occupancy/issue/wakeup counters.
package rs_pkg;

  localparam int RS_SIZE = 32;
  localparam int RS_RW   = 6;
  localparam int RS_ROBW = 4;
  localparam int RS_OPW  = 3;

  localparam logic [RS_OPW-1:0] ADD = 3'b000;
  localparam logic [RS_OPW-1:0] SUB = 3'b001;
  localparam logic [RS_OPW-1:0] AND = 3'b010;
  localparam logic [RS_OPW-1:0] XOR = 3'b011;
  localparam logic [RS_OPW-1:0] SRA = 3'b100;
  localparam logic [RS_OPW-1:0] LW  = 3'b101;
  localparam logic [RS_OPW-1:0] SW  = 3'b110;

  typedef enum logic {FC_ALU, FC_MEM} fu_class_e;

  typedef struct packed {
    logic [RS_OPW-1:0]  op;
    logic [RS_RW-1:0]   src1;
    logic [RS_RW-1:0]   src2;
    logic [RS_RW-1:0]   dest;
    logic               use_imm;
    logic [RS_SIZE-1:0] imm;
    logic [RS_ROBW-1:0] robn;
    logic               rdy1;
    logic               rdy2;
    fu_class_e          cls;
  } rs_entry_t;

  function automatic logic is_mem_op(
    input logic [RS_OPW-1:0] op
  );
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Picks up to N eligible entries, oldest first, as one-hot grants.
// age[i][j]=1 means entry j is older than entry i.
module rs_age_select #(
  parameter int ENTRIES = 16,
  parameter int N       = 1
) (
  input  logic [ENTRIES-1:0]              i_elig,
  input  logic [ENTRIES-1:0][ENTRIES-1:0] i_age,
  output logic [N-1:0][ENTRIES-1:0]       o_gnt
);

  logic [ENTRIES-1:0] w_rem;

  always_comb begin
    w_rem = i_elig;
    o_gnt = '0;
    for (int n = 0; n < N; n++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_rem[i] && ((i_age[i] & w_rem) == '0))
          o_gnt[n][i] = 1'b1;
      end
      w_rem = w_rem & ~o_gnt[n];
    end
  end

endmodule

// File: rtl/rs_multi_issue.sv
// Reservation station: DISP_W-wide dispatch, tag wakeup, age-ordered issue.
// Define RS_STATS_EN to add saturating stat_* counters.
module rs_multi_issue
  import rs_pkg::*;
#(
  parameter int SIZE       = RS_SIZE,
  parameter int REG_NUM    = 64,
  parameter int ROB_ROWS   = 16,
  parameter int ALUOP_BITS = RS_OPW,
  parameter int ENTRIES    = 16,
  parameter int DISP_W     = 2,
  parameter int NUM_ALU    = 2,
  parameter int WB_W       = 3,
  localparam int RW   = $clog2(REG_NUM),
  localparam int ROBW = $clog2(ROB_ROWS),
  localparam int OW   = $clog2(ENTRIES+1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DISP_W-1:0]                   disp_valid,
  output logic                                disp_ready,
  input  logic [DISP_W-1:0][ALUOP_BITS-1:0]   disp_op,
  input  logic [DISP_W-1:0][RW-1:0]           disp_src1,
  input  logic [DISP_W-1:0][RW-1:0]           disp_src2,
  input  logic [DISP_W-1:0][RW-1:0]           disp_dest,
  input  logic [DISP_W-1:0]                   disp_use_imm,
  input  logic [DISP_W-1:0][SIZE-1:0]         disp_imm,
  input  logic [DISP_W-1:0][ROBW-1:0]         disp_robn,
  input  logic [WB_W-1:0]                     wb_valid,
  input  logic [WB_W-1:0][RW-1:0]             wb_tag,
  output logic [NUM_ALU-1:0]                  alu_valid,
  input  logic [NUM_ALU-1:0]                  alu_ready,
  output logic [NUM_ALU-1:0][ALUOP_BITS-1:0]  alu_op,
  output logic [NUM_ALU-1:0][RW-1:0]          alu_src1,
  output logic [NUM_ALU-1:0][RW-1:0]          alu_src2,
  output logic [NUM_ALU-1:0][RW-1:0]          alu_dest,
  output logic [NUM_ALU-1:0]                  alu_use_imm,
  output logic [NUM_ALU-1:0][SIZE-1:0]        alu_imm,
  output logic [NUM_ALU-1:0][ROBW-1:0]        alu_robn,
  output logic                                mem_valid,
  input  logic                                mem_ready,
  output logic [ALUOP_BITS-1:0]               mem_op,
  output logic [RW-1:0]                       mem_src1,
  output logic [RW-1:0]                       mem_src2,
  output logic [RW-1:0]                       mem_dest,
  output logic                                mem_use_imm,
  output logic [SIZE-1:0]                     mem_imm,
  output logic [ROBW-1:0]                     mem_robn,
  input  logic                                flush,
  output logic [OW-1:0]                       occupancy
`ifdef RS_STATS_EN
  ,
  output logic [31:0]                         stat_full_cycles,
  output logic [31:0]                         stat_issued,
  output logic [31:0]                         stat_wakeups
`endif
);

  localparam int IW = $clog2(ENTRIES);

  rs_entry_t                     r_ent [ENTRIES];
  logic [ENTRIES-1:0]            r_valid;
  logic [ENTRIES-1:0][ENTRIES-1:0] r_age;
  logic [REG_NUM-1:0]            r_sb;

  logic [ENTRIES-1:0]            w_elig_alu, w_elig_mem;
  logic [ENTRIES-1:0]            w_wk1, w_wk2, w_iss;
  logic [ENTRIES-1:0]            w_taken, w_alloc;
  logic [DISP_W-1:0][IW-1:0]     w_slot_idx;
  logic [DISP_W-1:0]             w_slot_en;
  logic [DISP_W-1:0][ENTRIES-1:0] w_row;
  rs_entry_t                     w_new [DISP_W];
  logic                          w_acc;
  logic [ENTRIES-1:0][ENTRIES-1:0] w_age_nxt;
  logic [REG_NUM-1:0]            w_sb_nxt;
  logic [NUM_ALU-1:0][ENTRIES-1:0] w_agnt;
  logic [0:0][ENTRIES-1:0]       w_mgnt;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < ENTRIES; i++)
      occupancy = occupancy + OW'(r_valid[i]);
  end

  assign disp_ready = (ENTRIES - int'(occupancy)) >= DISP_W;
  assign w_acc = disp_ready && (|disp_valid);

  always_comb begin
    w_wk1 = '0;
    w_wk2 = '0;
    w_elig_alu = '0;
    w_elig_mem = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int k = 0; k < WB_W; k++) begin
        if (wb_valid[k] && r_ent[i].src1 == wb_tag[k]) w_wk1[i] = 1'b1;
        if (wb_valid[k] && r_ent[i].src2 == wb_tag[k]) w_wk2[i] = 1'b1;
      end
      if (r_valid[i] && r_ent[i].rdy1 && r_ent[i].rdy2) begin
        w_elig_alu[i] = (r_ent[i].cls == FC_ALU);
        w_elig_mem[i] = (r_ent[i].cls == FC_MEM);
      end
    end
  end

  rs_age_select #(.ENTRIES(ENTRIES), .N(NUM_ALU)) u_sel_alu (
    .i_elig (w_elig_alu),
    .i_age  (r_age),
    .o_gnt  (w_agnt)
  );

  rs_age_select #(.ENTRIES(ENTRIES), .N(1)) u_sel_mem (
    .i_elig (w_elig_mem),
    .i_age  (r_age),
    .o_gnt  (w_mgnt)
  );

  always_comb begin
    alu_valid = '0; alu_op = '0; alu_src1 = '0;
    alu_src2 = '0; alu_dest = '0; alu_use_imm = '0;
    alu_imm = '0; alu_robn = '0;
    mem_valid = 1'b0; mem_op = '0; mem_src1 = '0;
    mem_src2 = '0; mem_dest = '0; mem_use_imm = 1'b0;
    mem_imm = '0; mem_robn = '0;
    w_iss = '0;
    for (int p = 0; p < NUM_ALU; p++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_agnt[p][i]) begin
          alu_valid[p]   = 1'b1;
          alu_op[p]      = r_ent[i].op;
          alu_src1[p]    = r_ent[i].src1;
          alu_src2[p]    = r_ent[i].src2;
          alu_dest[p]    = r_ent[i].dest;
          alu_use_imm[p] = r_ent[i].use_imm;
          alu_imm[p]     = r_ent[i].imm;
          alu_robn[p]    = r_ent[i].robn;
          if (alu_ready[p]) w_iss[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_mgnt[0][i]) begin
        mem_valid   = 1'b1;
        mem_op      = r_ent[i].op;
        mem_src1    = r_ent[i].src1;
        mem_src2    = r_ent[i].src2;
        mem_dest    = r_ent[i].dest;
        mem_use_imm = r_ent[i].use_imm;
        mem_imm     = r_ent[i].imm;
        mem_robn    = r_ent[i].robn;
        if (mem_ready) w_iss[i] = 1'b1;
      end
    end
  end

  // Slots take the lowest currently-free indices; issuing entries stay busy.
  always_comb begin
    logic w_found;
    w_taken = r_valid;
    w_alloc = '0;
    w_slot_idx = '0;
    w_slot_en = '0;
    for (int s = 0; s < DISP_W; s++) begin
      w_found = 1'b0;
      if (disp_valid[s]) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!w_found && !w_taken[i]) begin
            w_found = 1'b1;
            w_taken[i] = 1'b1;
            w_alloc[i] = 1'b1;
            w_slot_idx[s] = IW'(i);
          end
        end
      end
      w_slot_en[s] = w_found;
    end
  end

  always_comb begin
    for (int s = 0; s < DISP_W; s++) begin
      w_new[s].op      = disp_op[s];
      w_new[s].src1    = disp_src1[s];
      w_new[s].src2    = disp_src2[s];
      w_new[s].dest    = disp_dest[s];
      w_new[s].use_imm = disp_use_imm[s];
      w_new[s].imm     = disp_imm[s];
      w_new[s].robn    = disp_robn[s];
      w_new[s].cls     = is_mem_op(disp_op[s]) ? FC_MEM : FC_ALU;
      w_new[s].rdy1    = r_sb[disp_src1[s]];
      w_new[s].rdy2    = r_sb[disp_src2[s]];
      for (int k = 0; k < WB_W; k++) begin
        if (wb_valid[k] && wb_tag[k] == disp_src1[s]) w_new[s].rdy1 = 1'b1;
        if (wb_valid[k] && wb_tag[k] == disp_src2[s]) w_new[s].rdy2 = 1'b1;
      end
      w_row[s] = r_valid;
      for (int j = 0; j < s; j++) begin
        if (disp_valid[j] && disp_dest[j] != '0) begin
          if (disp_dest[j] == disp_src1[s]) w_new[s].rdy1 = 1'b0;
          if (disp_dest[j] == disp_src2[s]) w_new[s].rdy2 = 1'b0;
        end
        if (w_slot_en[j]) w_row[s][w_slot_idx[j]] = 1'b1;
      end
      if (disp_use_imm[s]) w_new[s].rdy2 = 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < ENTRIES; r++)
      w_age_nxt[r] = r_age[r] & ~(w_acc ? w_alloc : '0);
    for (int s = 0; s < DISP_W; s++)
      if (w_acc && w_slot_en[s]) w_age_nxt[w_slot_idx[s]] = w_row[s];
  end

  // Dispatch clears after writeback sets, so a same-tag collision stays busy.
  always_comb begin
    w_sb_nxt = r_sb;
    for (int k = 0; k < WB_W; k++)
      if (wb_valid[k]) w_sb_nxt[wb_tag[k]] = 1'b1;
    for (int s = 0; s < DISP_W; s++)
      if (w_acc && disp_valid[s]) w_sb_nxt[disp_dest[s]] = 1'b0;
    w_sb_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      r_age   <= '0;
      r_sb    <= '1;
    end else begin
      r_valid <= (r_valid & ~w_iss) | (w_acc ? w_alloc : '0);
      r_age   <= w_age_nxt;
      r_sb    <= w_sb_nxt;
      for (int i = 0; i < ENTRIES; i++) begin
        if (r_valid[i] && w_wk1[i]) r_ent[i].rdy1 <= 1'b1;
        if (r_valid[i] && w_wk2[i]) r_ent[i].rdy2 <= 1'b1;
      end
      for (int s = 0; s < DISP_W; s++)
        if (w_acc && w_slot_en[s]) r_ent[w_slot_idx[s]] <= w_new[s];
    end
  end

`ifdef RS_STATS_EN
  logic [31:0] w_n_iss, w_n_wk;

  always_comb begin
    w_n_iss = 32'(mem_valid && mem_ready);
    for (int p = 0; p < NUM_ALU; p++)
      w_n_iss = w_n_iss + 32'(alu_valid[p] && alu_ready[p]);
    w_n_wk = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_n_wk = w_n_wk + 32'(r_valid[i] && w_wk1[i] && !r_ent[i].rdy1);
      w_n_wk = w_n_wk + 32'(r_valid[i] && w_wk2[i] && !r_ent[i].rdy2);
    end
  end

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_full_cycles <= '0;
      stat_issued      <= '0;
      stat_wakeups     <= '0;
    end else if (flush) begin
      stat_full_cycles <= '0;
      stat_issued      <= w_n_iss;
      stat_wakeups     <= '0;
    end else begin
      stat_full_cycles <= sat_add(stat_full_cycles, 32'(!disp_ready));
      stat_issued      <= sat_add(stat_issued, w_n_iss);
      stat_wakeups     <= sat_add(stat_wakeups, w_n_wk);
    end
  end
`endif

endmodule
